// File: rtl/load_align_unit.sv
// MEM-stage load unit: issues a word-aligned read and returns the extracted, extended load result.
// Build option: define LOAD_MISALIGN_TRAP_EN to trap misaligned LH/LHU/LW without a memory access.
module load_align_unit #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [2:0]        ld_op,
    input  logic [4:0]        ld_rd,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [31:0]       wb_data,
    output logic [4:0]        wb_rd,
    output logic              wb_err,
    output logic              wb_misalign
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

    localparam logic [2:0] OpLb  = 3'b000;
    localparam logic [2:0] OpLh  = 3'b001;
    localparam logic [2:0] OpLbu = 3'b100;
    localparam logic [2:0] OpLhu = 3'b101;

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e            state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic [2:0]        op_q, op_d;
    logic [4:0]        rd_q, rd_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              mem_req_q, mem_req_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              wb_valid_q, wb_valid_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic              wb_err_q, wb_err_d;
    logic              wb_misalign_q, wb_misalign_d;

    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic [31:0]       load_word;
    logic              misalign;

    // Big-endian lanes: byte 0 sits in the top bits of the word.
    always_comb begin
        unique case (sel_q)
            2'd0:    rd_byte = mem_rdata[31:24];
            2'd1:    rd_byte = mem_rdata[23:16];
            2'd2:    rd_byte = mem_rdata[15:8];
            default: rd_byte = mem_rdata[7:0];
        endcase
        rd_half = sel_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
        case (op_q)
            OpLb:    load_word = {{24{rd_byte[7]}}, rd_byte};
            OpLbu:   load_word = {24'h0, rd_byte};
            OpLh:    load_word = {{16{rd_half[15]}}, rd_half};
            OpLhu:   load_word = {16'h0, rd_half};
            default: load_word = mem_rdata;
        endcase
    end

`ifdef LOAD_MISALIGN_TRAP_EN
    always_comb begin
        case (ld_op)
            OpLb, OpLbu: misalign = 1'b0;
            OpLh, OpLhu: misalign = ld_addr[0];
            default:     misalign = |ld_addr[1:0];
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        op_d          = op_q;
        rd_d          = rd_q;
        cnt_d         = cnt_q;
        mem_req_d     = mem_req_q;
        mem_addr_d    = mem_addr_q;
        wb_valid_d    = wb_valid_q;
        wb_data_d     = wb_data_q;
        wb_rd_d       = wb_rd_q;
        wb_err_d      = wb_err_q;
        wb_misalign_d = wb_misalign_q;
        unique case (state_q)
            StIdle: begin
                if (ld_valid) begin
                    sel_d      = ld_addr[1:0];
                    op_d       = ld_op;
                    rd_d       = ld_rd;
                    cnt_d      = '0;
                    mem_addr_d = {ld_addr[ADDR_W-1:2], 2'b00};
                    if (misalign) begin
                        state_d       = StResp;
                        wb_valid_d    = 1'b1;
                        wb_data_d     = 32'h0;
                        wb_rd_d       = ld_rd;
                        wb_err_d      = 1'b0;
                        wb_misalign_d = 1'b1;
                    end else begin
                        state_d   = StReq;
                        mem_req_d = 1'b1;
                    end
                end
            end
            StReq: begin
                // An ack on the final allowed cycle still beats the timeout.
                if (mem_ack) begin
                    state_d       = StResp;
                    mem_req_d     = 1'b0;
                    wb_valid_d    = 1'b1;
                    wb_data_d     = load_word;
                    wb_rd_d       = rd_q;
                    wb_err_d      = 1'b0;
                    wb_misalign_d = 1'b0;
                end else if (cnt_q == CntLast) begin
                    state_d       = StResp;
                    mem_req_d     = 1'b0;
                    wb_valid_d    = 1'b1;
                    wb_data_d     = 32'h0;
                    wb_rd_d       = rd_q;
                    wb_err_d      = 1'b1;
                    wb_misalign_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                if (wb_ready) begin
                    state_d    = StIdle;
                    wb_valid_d = 1'b0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            sel_q         <= 2'b00;
            op_q          <= 3'b000;
            rd_q          <= 5'd0;
            cnt_q         <= '0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            wb_valid_q    <= 1'b0;
            wb_data_q     <= 32'h0;
            wb_rd_q       <= 5'd0;
            wb_err_q      <= 1'b0;
            wb_misalign_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            op_q          <= op_d;
            rd_q          <= rd_d;
            cnt_q         <= cnt_d;
            mem_req_q     <= mem_req_d;
            mem_addr_q    <= mem_addr_d;
            wb_valid_q    <= wb_valid_d;
            wb_data_q     <= wb_data_d;
            wb_rd_q       <= wb_rd_d;
            wb_err_q      <= wb_err_d;
            wb_misalign_q <= wb_misalign_d;
        end
    end

    assign ld_ready    = (state_q == StIdle);
    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign wb_valid    = wb_valid_q;
    assign wb_data     = wb_data_q;
    assign wb_rd       = wb_rd_q;
    assign wb_err      = wb_err_q;
    assign wb_misalign = wb_misalign_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Randomized self-checking bench for load_align_unit: expected outputs come from an arithmetic
// load model and a transaction-level timeline, compared on every falling edge.
module tb_load_align_unit;

    localparam int unsigned ADDR_W  = 32;
    localparam int unsigned TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_addr;
    logic [2:0]        ld_op;
    logic [4:0]        ld_rd;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    logic              wb_valid;
    logic              wb_ready;
    logic [31:0]       wb_data;
    logic [4:0]        wb_rd;
    logic              wb_err;
    logic              wb_misalign;

    load_align_unit #(
        .ADDR_W  (ADDR_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_addr     (ld_addr),
        .ld_op       (ld_op),
        .ld_rd       (ld_rd),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .wb_valid    (wb_valid),
        .wb_ready    (wb_ready),
        .wb_data     (wb_data),
        .wb_rd       (wb_rd),
        .wb_err      (wb_err),
        .wb_misalign (wb_misalign)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    logic chk_en   = 1'b0;

    // Expected DUT state, advanced by the stimulus timeline.
    logic        exp_ready, exp_req, exp_valid, exp_err, exp_mis;
    logic [31:0] exp_maddr, exp_data;
    logic [4:0]  exp_rd;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr,
                                             input logic [31:0] word);
        int unsigned b, h;
        int          v;
        b = addr % 4;
        h = (addr / 2) % 2;
        case (op)
            3'd0, 3'd4: begin
                v = int'((word >> (8 * (3 - b))) & 32'hFF);
                if (op == 3'd0 && v >= 128) v = v - 256;
            end
            3'd1, 3'd5: begin
                v = int'((word >> (16 * (1 - h))) & 32'hFFFF);
                if (op == 3'd1 && v >= 32768) v = v - 65536;
            end
            default: v = int'(word);
        endcase
        return 32'(v);
    endfunction

    function automatic bit ref_misalign(input logic [2:0] op, input logic [31:0] addr);
        bit mis;
        if (op == 3'd0 || op == 3'd4)      mis = 1'b0;
        else if (op == 3'd1 || op == 3'd5) mis = (addr % 2) != 0;
        else                               mis = (addr % 4) != 0;
`ifndef LOAD_MISALIGN_TRAP_EN
        mis = 1'b0;
`endif
        return mis;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ld_ready", 32'(ld_ready), 32'(exp_ready));
            chk("mem_req", 32'(mem_req), 32'(exp_req));
            if (exp_req) chk("mem_addr", mem_addr, exp_maddr);
            chk("wb_valid", 32'(wb_valid), 32'(exp_valid));
            if (exp_valid) begin
                chk("wb_data", wb_data, exp_data);
                chk("wb_rd", 32'(wb_rd), 32'(exp_rd));
                chk("wb_err", 32'(wb_err), 32'(exp_err));
                chk("wb_misalign", 32'(wb_misalign), 32'(exp_mis));
            end
`ifndef LOAD_MISALIGN_TRAP_EN
            chk("misalign_tied0", 32'(wb_misalign), 32'd0);
`endif
        end
    end

    task automatic reset_values(input string tag);
        chk({tag, "_ld_ready"}, 32'(ld_ready), 32'd1);
        chk({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_wb_valid"}, 32'(wb_valid), 32'd0);
        chk({tag, "_wb_data"}, wb_data, 32'd0);
        chk({tag, "_wb_rd"}, 32'(wb_rd), 32'd0);
        chk({tag, "_wb_err"}, 32'(wb_err), 32'd0);
        chk({tag, "_wb_misalign"}, 32'(wb_misalign), 32'd0);
    endtask

    // Runs one load from an idle unit; returns at posedge+1 with the unit idle again.
    task automatic do_load(input logic [2:0] op, input logic [31:0] addr, input logic [4:0] rd,
                           input logic [31:0] word, input bit ack_en, input int unsigned ack_dly,
                           input int unsigned rdy_dly, output logic [31:0] got_data,
                           output logic got_err, output logic got_mis);
        int unsigned k;
        bit          done, acked;
        ld_valid = 1'b1;
        ld_addr  = addr;
        ld_op    = op;
        ld_rd    = rd;
        @(posedge clk); #1;
        ld_valid  = 1'b0;
        ld_addr   = $urandom;
        exp_ready = 1'b0;
        exp_rd    = rd;
        exp_maddr = {addr[31:2], 2'b00};
        if (ref_misalign(op, addr)) begin
            exp_valid = 1'b1;
            exp_data  = 32'h0;
            exp_err   = 1'b0;
            exp_mis   = 1'b1;
        end else begin
            exp_req = 1'b1;
            k       = 0;
            done    = 1'b0;
            while (!done) begin
                k++;
                acked     = ack_en && (k == ack_dly);
                mem_ack   = acked;
                mem_rdata = acked ? word : $urandom;
                ld_valid  = 1'($urandom);
                ld_addr   = $urandom;
                @(posedge clk); #1;
                mem_ack = 1'b0;
                if (acked || k == TIMEOUT) begin
                    exp_req   = 1'b0;
                    exp_valid = 1'b1;
                    exp_data  = acked ? ref_load(op, addr, word) : 32'h0;
                    exp_err   = !acked;
                    exp_mis   = 1'b0;
                    done      = 1'b1;
                end
            end
        end
        got_data = wb_data;
        got_err  = wb_err;
        got_mis  = wb_misalign;
        for (int i = 0; i < int'(rdy_dly); i++) begin
            wb_ready  = 1'b0;
            mem_ack   = 1'($urandom);
            mem_rdata = $urandom;
            ld_valid  = 1'($urandom);
            @(posedge clk); #1;
        end
        wb_ready = 1'b1;
        ld_valid = 1'b0;
        mem_ack  = 1'b0;
        @(posedge clk); #1;
        wb_ready  = 1'b0;
        exp_valid = 1'b0;
        exp_ready = 1'b1;
    endtask

    task automatic lit_load(input string name, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] word, input int unsigned ack_dly,
                            input int unsigned rdy_dly, input logic [31:0] want_data,
                            input logic want_err, input logic want_mis);
        logic [31:0] d;
        logic        e, m;
        do_load(op, addr, 5'd7, word, 1'b1, ack_dly, rdy_dly, d, e, m);
        chk({name, "_data"}, d, want_data);
        chk({name, "_err"}, 32'(e), 32'(want_err));
        chk({name, "_mis"}, 32'(m), 32'(want_mis));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic        e, m;
        rst_n     = 1'b0;
        ld_valid  = 1'b0;
        ld_addr   = '0;
        ld_op     = 3'd0;
        ld_rd     = 5'd0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        wb_ready  = 1'b0;
        exp_ready = 1'b1;
        exp_req   = 1'b0;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        exp_mis   = 1'b0;
        exp_maddr = 32'h0;
        exp_data  = 32'h0;
        exp_rd    = 5'd0;
        #12;
        reset_values("por");
        @(posedge clk); #1;
        rst_n  = 1'b1;
        chk_en = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        lit_load("lb101", 3'b000, 32'h101, 32'h8899AABB, 1, 0, 32'hFFFFFF99, 1'b0, 1'b0);
        lit_load("lbu101", 3'b100, 32'h101, 32'h8899AABB, 1, 0, 32'h00000099, 1'b0, 1'b0);
        lit_load("lh102", 3'b001, 32'h102, 32'h8899AABB, 1, 0, 32'hFFFFAABB, 1'b0, 1'b0);
        lit_load("lhu100", 3'b101, 32'h100, 32'h8899AABB, 1, 0, 32'h00008899, 1'b0, 1'b0);
        lit_load("lw100", 3'b011, 32'h100, 32'h8899AABB, 1, 0, 32'h8899AABB, 1'b0, 1'b0);
        lit_load("slow", 3'b011, 32'h100, 32'h12345678, 5, 4, 32'h12345678, 1'b0, 1'b0);
        lit_load("ack15", 3'b011, 32'h200, 32'hCAFEF00D, 15, 1, 32'hCAFEF00D, 1'b0, 1'b0);
        do_load(3'b011, 32'h300, 5'd3, 32'h0, 1'b0, 0, 2, d, e, m);
        chk("timeout_data", d, 32'h0);
        chk("timeout_err", 32'(e), 32'd1);
`ifdef LOAD_MISALIGN_TRAP_EN
        lit_load("lw102", 3'b011, 32'h102, 32'h8899AABB, 1, 0, 32'h0, 1'b0, 1'b1);
`else
        lit_load("lw102", 3'b011, 32'h102, 32'h8899AABB, 1, 0, 32'h8899AABB, 1'b0, 1'b0);
`endif

        // Reset while a request is outstanding, then a stray ack.
        ld_valid = 1'b1;
        ld_addr  = 32'h204;
        ld_op    = 3'b011;
        ld_rd    = 5'd9;
        @(posedge clk); #1;
        ld_valid  = 1'b0;
        exp_ready = 1'b0;
        exp_req   = 1'b1;
        exp_maddr = 32'h204;
        repeat (3) begin @(posedge clk); #1; end
        chk_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        reset_values("midreq");
        @(posedge clk); #1;
        rst_n     = 1'b1;
        exp_ready = 1'b1;
        exp_req   = 1'b0;
        exp_valid = 1'b0;
        chk_en    = 1'b1;
        mem_ack   = 1'b1;
        repeat (4) begin mem_rdata = $urandom; @(posedge clk); #1; end
        mem_ack = 1'b0;

        for (int t = 0; t < 200; t++) begin
            logic [2:0]  op;
            logic [31:0] addr;
            op   = 3'($urandom_range(0, 7));
            addr = $urandom;
            if ($urandom_range(0, 3) == 0) addr[1:0] = 2'b00;
            do_load(op, addr, 5'($urandom), $urandom, $urandom_range(0, 7) != 0,
                    $urandom_range(1, TIMEOUT + 2), $urandom_range(0, 3), d, e, m);
            repeat ($urandom_range(0, 2)) begin
                mem_ack   = 1'($urandom);
                mem_rdata = $urandom;
                @(posedge clk); #1;
            end
            mem_ack = 1'b0;
        end

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_align_unit.md
# load_align_unit

Memory-stage load unit for the 4-stage MIPS pipeline. It accepts one load (LB/LBU/LH/LHU/LW) from the MEM stage and issues a word-aligned read to data memory over a req/ack handshake. It then extracts and sign/zero-extends the addressed byte or halfword, and holds the 32-bit result for writeback under a valid/ready handshake. It feeds the register-file write port and absorbs the halfword/byte sign extension done at writeback.

## Interface
- ADDR_W, 32: byte address width.
- TIMEOUT, 15: REQ-state cycles without mem_ack before a bus error is reported (≥1).
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ld_valid  in  1  load request present.
- ld_ready  out  1  unit idle; request accepted when ld_valid & ld_ready at clk edge.
- ld_addr  in  ADDR_W  byte address.
- ld_op  in  3  opcode[2:0]: 000 LB, 001 LH, 011 LW, 100 LBU, 101 LHU; other codes are treated as LW.
- ld_rd  in  5  destination register tag.
- mem_req  out  1  read request to data memory.
- mem_addr  out  ADDR_W  {ld_addr[ADDR_W-1:2], 2'b00}.
- mem_ack  in  1  read data valid this cycle.
- mem_rdata  in  32  read word, big-endian (byte 0 = bits 31:24).
- wb_valid  out  1  result available.
- wb_ready  in  1  writeback consumes result.
- wb_data  out  32  extended load result.
- wb_rd  out  5  tag of the result.
- wb_err  out  1  bus timeout; wb_data = 0.
- wb_misalign  out  1  misaligned access; only driven in LOAD_MISALIGN_TRAP_EN builds, otherwise tied 0.

## Operation
- States: IDLE, REQ, RESP. All outputs are registered except ld_ready, which equals (state==IDLE).
- IDLE: on accept, latch addr, op, and rd, clear the timeout counter, and go to REQ. mem_ack is ignored.
- REQ: mem_req=1 and mem_addr is held stable.
  - mem_ack=1: capture the aligned result and go to RESP with wb_err=0.
  - Otherwise the counter increments. When it reaches TIMEOUT, go to RESP with wb_err=1 and wb_data=0.
  - If ack arrives on the TIMEOUT-th cycle, ack wins.
- RESP: wb_valid=1 and wb_data, wb_rd, wb_err, wb_misalign are held stable until wb_valid & wb_ready. Then go to IDLE. mem_ack is ignored.
- Extraction, with sel = latched addr[1:0]:
  - Byte = mem_rdata[31-8*sel -: 8].
  - Halfword = addr[1] ? mem_rdata[15:0] : mem_rdata[31:16].
  - LB/LH replicate the MSB into the upper bits. LBU/LHU zero-fill. LW passes the word unchanged.
- Without the macro, halfword ignores addr[0] and LW ignores addr[1:0].
- Reset (async, any state): state=IDLE, mem_req=0, mem_addr=0, wb_valid=0, wb_data=0, wb_rd=0, wb_err=0, wb_misalign=0, counter=0. An in-flight load is dropped, and a late mem_ack after reset is ignored.

## Timing
- Accept at edge N, mem_req=1 from cycle N+1.
- mem_ack sampled at edge M (with mem_req=1) gives wb_valid=1 from cycle M+1. Minimum accept-to-wb_valid is 2 cycles.
- mem_req falls in the cycle after the acking edge. Single-cycle ack pulse per request.
- Next accept is possible at the edge after the wb handshake edge, so best-case throughput is 1 load per 3 cycles.
- Timeout: with no ack, wb_valid rises TIMEOUT+1 cycles after accept.

## Configuration
- LOAD_MISALIGN_TRAP_EN defined:
  - On accept, LH/LHU with addr[0]=1, or LW with addr[1:0]≠0, skips REQ: no mem_req is issued.
  - The unit goes directly to RESP next cycle with wb_misalign=1, wb_data=0, wb_err=0.
- Undefined: no misalignment check. Low address bits are ignored as above and wb_misalign is constant 0.

## Test plan
- mem_rdata=0x8899AABB, ack 1 cycle after mem_req; LB @0x101 → 0xFFFFFF99, LBU @0x101 → 0x00000099, LH @0x102 → 0xFFFFAABB, LHU @0x100 → 0x00008899, LW @0x100 → 0x8899AABB. mem_addr=0x100 in all cases, wb_rd equals ld_rd.
- Ack delayed 5 cycles, wb_ready held low 4 cycles in RESP → mem_addr stable throughout, wb_data/wb_rd stable until handshake, ld_ready=0 until the cycle after handshake.
- No ack, TIMEOUT=15 → wb_valid 16 cycles after accept with wb_err=1, wb_data=0. A separate run with ack on the 15th REQ cycle → valid data, wb_err=0.
- rst_n pulsed low while in REQ → mem_req drops immediately, outputs at reset values. mem_ack asserted after reset release → no wb_valid.
- Macro defined, LW @0x102 → no mem_req, wb_valid next cycle with wb_misalign=1, wb_data=0. Macro undefined, same stimulus → normal LW of word 0x100.
